// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every non-clock, non-reset signal of the memory-port arbiter:
// the two requester request/response channels and the memory-side bus.
//   req0_* / req1_*   request handshake, direction and payload per port
//   rsp0_* / rsp1_*   one-cycle response pulse and error flag per port
//   rsp_rdata         load data shared by both ports
//   mem_*             single-ported data memory bus
// Modports:
//   slave  - the arbiter's view (receives requests, drives the memory)
//   master - the environment's view (requesters plus memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [31:0]       req0_wdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [31:0]       req1_wdata;
    logic              rsp0_valid;
    logic              rsp0_err;
    logic              rsp1_valid;
    logic              rsp1_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [1:0]        mem_control;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  mem_read_data,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, rsp_rdata,
        output mem_address, mem_control, mem_write_data
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output mem_read_data,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, rsp_rdata,
        input  mem_address, mem_control, mem_write_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter/sequencer for a single-ported byte-addressed data
// memory with 32-bit word access. Each accepted request is checked for
// alignment and range, presented to the memory for exactly one cycle, and
// answered with a one-cycle response pulse. Throughput: one access per
// three cycles (IDLE -> ACCESS -> RESP).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mem_port_arbiter_if.slave (requests, responses, memory bus)
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : round-robin between the two ports
//                       undefined : fixed priority, port 0 wins
module mem_port_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    logic [1:0]        state_q, state_d;
    logic              hold_port_q, hold_port_d;
    logic              hold_write_q, hold_write_d;
    logic              hold_err_q, hold_err_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_write_data_q, mem_write_data_d;
    logic [1:0]        mem_control_q, mem_control_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp0_err_q, rsp0_err_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic              rsp1_err_q, rsp1_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic              idle_s;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              sel_write_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              sel_err_s;

    // Ready is combinational on valid, so it is also gated by reset_n to
    // read 0 while reset is held even with a valid request pending.
    assign idle_s = (state_q == ST_IDLE) && reset_n;

`ifdef ARB_ROUND_ROBIN_EN
    // prio_q names the port that wins a simultaneous request.
    logic prio_q, prio_d;

    // Round-robin grant: the favoured port wins only on a collision.
    always_comb begin
        gnt0_s = idle_s && bus.req0_valid && (!bus.req1_valid || !prio_q);
        gnt1_s = idle_s && bus.req1_valid && (!bus.req0_valid ||  prio_q);
        if (gnt0_s || gnt1_s) begin
            prio_d = ~gnt1_s;
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority pointer register; favours port 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed-priority grant: port 0 always wins a collision.
    always_comb begin
        gnt0_s = idle_s && bus.req0_valid;
        gnt1_s = idle_s && bus.req1_valid && !bus.req0_valid;
    end
`endif

    // Select the winning request and evaluate its legality at capture.
    always_comb begin
        if (gnt1_s) begin
            sel_write_s = bus.req1_write;
            sel_addr_s  = bus.req1_addr;
            sel_wdata_s = bus.req1_wdata;
        end else begin
            sel_write_s = bus.req0_write;
            sel_addr_s  = bus.req0_addr;
            sel_wdata_s = bus.req0_wdata;
        end
        sel_err_s = (sel_addr_s[1:0] != 2'b00) || (sel_addr_s > LAST_WORD);
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        hold_port_d      = hold_port_q;
        hold_write_d     = hold_write_q;
        hold_err_d       = hold_err_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_control_d    = 2'b00;
        rsp0_valid_d     = 1'b0;
        rsp0_err_d       = 1'b0;
        rsp1_valid_d     = 1'b0;
        rsp1_err_d       = 1'b0;
        rsp_rdata_d      = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0_s || gnt1_s) begin
                    state_d          = ST_ACCESS;
                    hold_port_d      = gnt1_s;
                    hold_write_d     = sel_write_s;
                    hold_err_d       = sel_err_s;
                    mem_address_d    = sel_addr_s;
                    mem_write_data_d = sel_wdata_s;
                    // Control is registered here so it is valid exactly
                    // for the ACCESS cycle; an illegal request never
                    // touches the memory.
                    if (sel_err_s) begin
                        mem_control_d = 2'b00;
                    end else begin
                        mem_control_d = {~sel_write_s, sel_write_s};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (hold_err_q || hold_write_q) begin
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    rsp_rdata_d = bus.mem_read_data;
                end
                rsp0_valid_d = ~hold_port_q;
                rsp0_err_d   = ~hold_port_q & hold_err_q;
                rsp1_valid_d =  hold_port_q;
                rsp1_err_d   =  hold_port_q & hold_err_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, holding register and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            hold_port_q      <= 1'b0;
            hold_write_q     <= 1'b0;
            hold_err_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= 32'h0000_0000;
            mem_control_q    <= 2'b00;
            rsp0_valid_q     <= 1'b0;
            rsp0_err_q       <= 1'b0;
            rsp1_valid_q     <= 1'b0;
            rsp1_err_q       <= 1'b0;
            rsp_rdata_q      <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            hold_port_q      <= hold_port_d;
            hold_write_q     <= hold_write_d;
            hold_err_q       <= hold_err_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_control_q    <= mem_control_d;
            rsp0_valid_q     <= rsp0_valid_d;
            rsp0_err_q       <= rsp0_err_d;
            rsp1_valid_q     <= rsp1_valid_d;
            rsp1_err_q       <= rsp1_err_d;
            rsp_rdata_q      <= rsp_rdata_d;
        end
    end

    assign bus.req0_ready     = gnt0_s;
    assign bus.req1_ready     = gnt1_s;
    assign bus.rsp0_valid     = rsp0_valid_q;
    assign bus.rsp0_err       = rsp0_err_q;
    assign bus.rsp1_valid     = rsp1_valid_q;
    assign bus.rsp1_err       = rsp1_err_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_control    = mem_control_q;
    assign bus.mem_write_data = mem_write_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int two_ready = 0;
    int two_rsp = 0;
    int wr_count = 0;

    // Environment memory and the bench's independent reference of it.
    logic [7:0]  mem [0:1023];
    logic [31:0] ref_mem [int];

    rsp_t exp_q [$];
    rsp_t got_q [$];
    int   got_cyc_q [$];
    logic grant_q [$];
    int   grant_cyc_q [$];
    logic [1:0] ctl_q [$];
    int   ctl_cyc_q [$];

    logic [9:0] rd_idx;
    always_comb begin
        rd_idx = bus.mem_address[9:0];
        bus.mem_read_data = {mem[10'(rd_idx + 10'd3)], mem[10'(rd_idx + 10'd2)],
                             mem[10'(rd_idx + 10'd1)], mem[rd_idx]};
    end

    always @(posedge clk) begin
        if (bus.mem_control == 2'b01) begin
            mem[bus.mem_address[9:0]]                  <= bus.mem_write_data[7:0];
            mem[10'(bus.mem_address[9:0] + 10'd1)]     <= bus.mem_write_data[15:8];
            mem[10'(bus.mem_address[9:0] + 10'd2)]     <= bus.mem_write_data[23:16];
            mem[10'(bus.mem_address[9:0] + 10'd3)]     <= bus.mem_write_data[31:24];
            wr_count <= wr_count + 1;
        end
    end

    // Monitor: logs handshakes (pushing expectations), control and responses.
    initial begin
        rsp_t        e;
        logic        hs;
        logic        hs_port;
        logic        hs_w;
        logic [31:0] hs_a;
        logic [31:0] hs_d;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (!reset_n) begin
                exp_q.delete();
                got_q.delete();
                got_cyc_q.delete();
            end else begin
                if (bus.req0_ready && bus.req1_ready) two_ready++;
                hs = 1'b0; hs_port = 1'b0; hs_w = 1'b0; hs_a = 32'h0; hs_d = 32'h0;
                if (bus.req0_valid && bus.req0_ready) begin
                    hs = 1'b1; hs_port = 1'b0; hs_w = bus.req0_write;
                    hs_a = bus.req0_addr; hs_d = bus.req0_wdata;
                end else if (bus.req1_valid && bus.req1_ready) begin
                    hs = 1'b1; hs_port = 1'b1; hs_w = bus.req1_write;
                    hs_a = bus.req1_addr; hs_d = bus.req1_wdata;
                end
                if (hs) begin
                    e.port = hs_port;
                    e.err  = (hs_a[1:0] != 2'b00) || (hs_a > 32'd1020);
                    e.rdata = 32'h0;
                    if (hs_w) begin
                        if (!e.err) ref_mem[int'(hs_a[31:2])] = hs_d;
                    end else if (!e.err && ref_mem.exists(int'(hs_a[31:2]))) begin
                        e.rdata = ref_mem[int'(hs_a[31:2])];
                    end
                    exp_q.push_back(e);
                    grant_q.push_back(hs_port);
                    grant_cyc_q.push_back(cyc_cnt);
                end
                if (bus.mem_control != 2'b00) begin
                    ctl_q.push_back(bus.mem_control);
                    ctl_cyc_q.push_back(cyc_cnt);
                end
                if (bus.rsp0_valid || bus.rsp1_valid) begin
                    if (bus.rsp0_valid && bus.rsp1_valid) two_rsp++;
                    got_q.push_back({bus.rsp1_valid,
                                     bus.rsp1_valid ? bus.rsp1_err : bus.rsp0_err,
                                     bus.rsp_rdata});
                    got_cyc_q.push_back(cyc_cnt);
                end
            end
        end
    end

    task automatic clear_logs();
        grant_q.delete(); grant_cyc_q.delete();
        ctl_q.delete(); ctl_cyc_q.delete();
        got_cyc_q.delete();
    endtask

    // Present one request, hold it until accepted, drop valid after the edge.
    task automatic drive(input int port, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        int n = 0;
        if (port == 0) begin
            bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_valid = 1'b1;
        end
        forever begin
            @(negedge clk);
            if ((port == 0) ? bus.req0_ready : bus.req1_ready) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL grant_timeout port=%0d got no ready, required ready within 200 cycles", port);
                break;
            end
        end
        @(posedge clk); #1;
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (got_q.size() < n && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL rsp_timeout got %0d responses, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.req0_valid = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp0_err, bus.rsp1_valid,
             bus.rsp1_err, bus.rsp_rdata, bus.mem_control, bus.mem_address,
             bus.mem_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b%b ctl=%b addr=%h rdata=%h, required all 0",
                     bus.req0_ready, bus.req1_ready, bus.mem_control, bus.mem_address, bus.rsp_rdata);
        end
        bus.req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_store_load();
        rsp_t g, e;
        clear_logs();
        drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        wait_rsp(1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL store_rsp got %h, required %h", g, e); end
            checks++;
            if (ctl_q.size() != 1 || ctl_q[0] !== 2'b01 || ctl_cyc_q[0] != grant_cyc_q[0] + 1) begin
                errors++;
                $display("FAIL store_ctl got n=%0d ctl=%b, required one 01 at grant+1",
                         ctl_q.size(), (ctl_q.size() > 0) ? ctl_q[0] : 2'bxx);
            end
            checks++;
            if (got_cyc_q[0] != grant_cyc_q[0] + 2) begin
                errors++;
                $display("FAIL store_rsp_latency got %0d, required 2", got_cyc_q[0] - grant_cyc_q[0]);
            end
        end
        clear_logs();
        drive(0, 1'b0, 32'h10, 32'h0);
        wait_rsp(1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g.rdata !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL load_rsp got %h, required %h", g, e);
            end
            checks++;
            if (ctl_q.size() != 1 || ctl_q[0] !== 2'b10 || got_cyc_q[0] != grant_cyc_q[0] + 2) begin
                errors++; $display("FAIL load_timing got n=%0d ctl, required one 10 and latency 2", ctl_q.size());
            end
        end
    endtask

    task automatic test_err_addr();
        rsp_t g, e;
        clear_logs();
        drive(1, 1'b0, 32'h3FE, 32'h0);
        wait_rsp(1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g.err !== 1'b1 || g.rdata !== 32'h0) begin
                errors++; $display("FAIL err_rsp got %h, required %h", g, e);
            end
        end
        checks++;
        if (ctl_q.size() != 0) begin
            errors++; $display("FAIL err_ctl got %0d nonzero control cycles, required 0", ctl_q.size());
        end
    endtask

    task automatic test_top_word();
        rsp_t g, e;
        drive(1, 1'b1, 32'h3FC, 32'hA5A5_5A5A);
        drive(1, 1'b0, 32'h3FC, 32'h0);
        wait_rsp(2);
        for (int i = 0; i < 2; i++) begin
            if (got_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                checks++;
                if (g !== e || g.err !== 1'b0) begin
                    errors++; $display("FAIL top_word[%0d] got %h, required %h", i, g, e);
                end
            end
        end
    endtask

    task automatic test_both_ports();
        rsp_t g, e;
        logic exp_port;
        clear_logs();
        two_ready = 0;
        fork
            for (int i = 0; i < 6; i++) begin
                drive(0, 1'b1, 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i));
            end
            for (int j = 0; j < 6; j++) begin
                if (j % 2 == 0) drive(1, 1'b0, 32'h10, 32'h0);
                else            drive(1, 1'b1, 32'h200 + 32'(4 * j), 32'h2222_0000 + 32'(j));
            end
        join
        wait_rsp(12);
        for (int i = 0; i < 12; i++) begin
            if (got_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                checks++;
                if (g !== e) begin errors++; $display("FAIL both_rsp[%0d] got %h, required %h", i, g, e); end
            end
        end
        for (int i = 0; i < 12; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_port = (i % 2 == 1);
`else
            exp_port = (i >= 6);
`endif
            checks++;
            if (i >= grant_q.size() || grant_q[i] !== exp_port) begin
                errors++;
                $display("FAIL grant_order[%0d] got %b, required %b", i,
                         (i < grant_q.size()) ? grant_q[i] : 1'bx, exp_port);
            end
        end
        checks++;
        if (two_ready != 0 || two_rsp != 0) begin
            errors++; $display("FAIL one_ready got %0d dual-ready %0d dual-rsp cycles, required 0", two_ready, two_rsp);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t g, e;
        clear_logs();
        drive(0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_rsp_cycle got rsp0_valid=%b, required 1", bus.rsp0_valid);
        end
        drive(0, 1'b0, 32'h100, 32'h0);
        wait_rsp(2);
        checks++;
        if (grant_cyc_q.size() != 2 || grant_cyc_q[1] - grant_cyc_q[0] != 3) begin
            errors++; $display("FAIL b2b_spacing got %0d grants spacing %0d, required 2 grants spacing 3",
                               grant_cyc_q.size(),
                               (grant_cyc_q.size() == 2) ? grant_cyc_q[1] - grant_cyc_q[0] : -1);
        end
        for (int i = 0; i < 2; i++) begin
            if (got_q.size() > 0) begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                checks++;
                if (g !== e) begin errors++; $display("FAIL b2b_rsp[%0d] got %h, required %h", i, g, e); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        rsp_t g, e;
        int wc0;
        clear_logs();
        wc0 = wr_count;
        drive(0, 1'b1, 32'h40, 32'h1234_5678);
        checks++;
        if (bus.mem_control !== 2'b01) begin
            errors++; $display("FAIL mid_access_ctl got %b, required 01", bus.mem_control);
        end
        bus.req1_write = 1'b0; bus.req1_addr = 32'h10; bus.req1_wdata = 32'h0; bus.req1_valid = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp0_err, bus.rsp1_valid,
             bus.rsp1_err, bus.rsp_rdata, bus.mem_control, bus.mem_address,
             bus.mem_write_data} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs ready=%b%b ctl=%b addr=%h wdata=%h rdata=%h, required all 0",
                     bus.req0_ready, bus.req1_ready, bus.mem_control, bus.mem_address,
                     bus.mem_write_data, bus.rsp_rdata);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            errors++; $display("FAIL first_edge_grant got req1_ready=%b, required 1", bus.req1_ready);
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_rsp(1);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL post_reset_rsp_count got %0d, required 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g.port !== 1'b1 || g.rdata !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL post_reset_rsp got %h, required %h", g, e);
            end
        end
        checks++;
        if (wr_count != wc0) begin
            errors++; $display("FAIL aborted_store got %0d writes, required 0", wr_count - wc0);
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = 32'h0; bus.req0_wdata = 32'h0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = 32'h0; bus.req1_wdata = 32'h0;
        test_reset();
        test_store_load();
        test_err_addr();
        test_top_word();
        test_both_ports();
        test_back_to_back();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion, required finish before 200000");
        $fatal(1);
    end
endmodule
